alu_iter_exec: RTL and testbench
================================

# alu_iter_exec

Multi-cycle execute-stage ALU that consumes the 4-bit ALU operation code and shift-select flag produced by the ALU control decoder, together with the register/immediate operands. Logic and arithmetic ops complete in one cycle; shifts run iteratively, one bit per cycle. Results go to the EX/MEM side through a valid/ready handshake. The block sits between operand selection and the EX/MEM pipeline register, and stalls the front end through `o_ready` while a shift iterates.

## Interface
- `BITS_DATA`, 32, operand/result width
- `ALU_OP`, 4, operation code width (matches decoder output)
- `BITS_SHAMT`, 5, shift amount width (log2 of BITS_DATA)

- `i_clk` input 1: single clock, rising edge
- `i_reset_n` input 1: asynchronous, active-low reset
- `i_valid` input 1: operation request present
- `o_ready` output 1: block accepts a request this cycle
- `i_alu_op` input ALU_OP: operation code
- `i_shamt_sel` input 1: 1 selects `i_shamt` as the shift amount; 0 selects `i_a[BITS_SHAMT-1:0]` (variable shift)
- `i_a` input BITS_DATA: operand A (rs)
- `i_b` input BITS_DATA: operand B (rt or immediate); this is the value that gets shifted
- `i_shamt` input BITS_SHAMT: instruction shamt field
- `o_valid` output 1: result valid
- `i_ready` input 1: downstream accepts the result
- `o_result` output BITS_DATA: result
- `o_zero` output 1: `o_result == 0`
- `o_overflow` output 1: signed overflow on ADD or SUB
- `o_illegal` output 1: the op code is not in the supported set

## Operation
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD (A+B), 0110 SUB (A−B), 0111 SLT (signed A<B → 1, else 0), 1100 NOR, 1101 XOR
  - 0011 SLL, 0100 SRL, 0101 SRA: shift B by the selected amount
  - Any other code: result 0, `o_illegal`=1, completes in one cycle.
- Arithmetic is modulo 2^BITS_DATA.
  - Overflow on ADD: both operand signs equal and the result sign differs.
  - Overflow on SUB: operand signs differ and the result sign differs from A.
  - Overflow is a flag only; it never aborts or traps. It is 0 for all other ops.
- State machine IDLE → (SHIFT) → DONE → IDLE:
  - IDLE: `o_ready`=1. On `i_valid`, capture all inputs.
    - Shift op with amount > 0: load the counter with the amount and go to SHIFT.
    - Otherwise: compute the result and go to DONE.
  - SHIFT: each cycle, shift the working register by 1 and decrement the counter. Counter 1→0 goes to DONE. SRA fills with the captured sign bit; SLL and SRL fill with 0.
  - DONE: `o_valid`=1 and outputs are held stable. On `i_ready`, go to IDLE.
- `o_ready`=0 in SHIFT and DONE. Requests there are ignored; the upstream stage holds them.
- A shift amount of 0 takes the non-iterative path: result = B.
- Reset mid-SHIFT or mid-DONE abandons the operation; no result is delivered.

## Timing
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_result`=0, `o_zero`=1, `o_overflow`=0, `o_illegal`=0, counter 0.
- Latency is measured from the accepting edge (`i_valid`&`o_ready`) to the first edge at which `o_valid` is sampled high:
  - 1 cycle for non-shift and zero-amount shift.
  - 1+k cycles for a shift by k (maximum 32 cycles for k=31).
- Outputs are registered; no combinational path from inputs to outputs except `o_ready` (pure state decode).
- Throughput is one op per 2 cycles minimum, because DONE→IDLE costs a cycle even with `i_ready` held high.
- Backpressure: `o_valid` stays high with constant `o_result` and flags until `i_ready`. Holding `i_ready` low indefinitely is legal.
- Inputs are sampled only at the accepting edge; later changes have no effect.

## Structure
- Shared package `mips_alu_pkg`: op code constants (AND, OR, ADD, SLL, SRL, SRA, SUB, SLT, NOR, XOR), a state enum, and BITS_SHAMT derivation. The decoder migrates to these constants.
- One sub-module, `alu_comb_core`: purely combinational single-cycle ops (AND/OR/ADD/SUB/SLT/NOR/XOR) plus the overflow and illegal-op flags.
- The top level holds the FSM, shift register, counter and output registers.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 with `i_ready`=1 → after 1 cycle, result 0x80000000, `o_overflow`=1, `o_zero`=0. Then SUB 5−5 → result 0, `o_zero`=1.
- SRA, `i_shamt_sel`=1, shamt=4, B=0xF0000000 → `o_valid` 5 cycles after accept, result 0xFF000000. `o_ready`=0 throughout.
- SLLV, `i_shamt_sel`=0, A=0x00000023 (amount 3), B=0x1 → result 0x8 after 4 cycles. A shift amount of 0 → result = B after 1 cycle.
- SLT A=0xFFFFFFFF, B=0x1 → result 1. Op 1010 → result 0, `o_illegal`=1.
- Hold `i_ready`=0 for 10 cycles in DONE while toggling inputs and `i_valid` → outputs constant, no new accept. Release → IDLE next cycle.
- Assert `i_reset_n`=0 during cycle 3 of a 20-bit SRL → all outputs return to reset values immediately. After release, a fresh AND 0xFF & 0x0F → 0x0F.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Purpose: shared ALU op codes, execute-stage FSM states and width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Shared by the ALU control decoder and the iterative execute ALU so both
// agree on the 4-bit op encoding.
package mips_alu_pkg;

  // Default datapath width and the shift-amount width derived from it.
  localparam int BITS_DATA_DEF  = 32;
  localparam int BITS_SHAMT_DEF = $clog2(BITS_DATA_DEF);

  // Operation code width produced by the ALU control decoder.
  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_AND = 4'b0000;
  localparam alu_op_t OP_OR  = 4'b0001;
  localparam alu_op_t OP_ADD = 4'b0010;
  localparam alu_op_t OP_SLL = 4'b0011;
  localparam alu_op_t OP_SRL = 4'b0100;
  localparam alu_op_t OP_SRA = 4'b0101;
  localparam alu_op_t OP_SUB = 4'b0110;
  localparam alu_op_t OP_SLT = 4'b0111;
  localparam alu_op_t OP_NOR = 4'b1100;
  localparam alu_op_t OP_XOR = 4'b1101;

  // Execute-stage sequencing.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // Shift ops are the only ones that may take the iterative path.
  function automatic logic is_shift_op(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purpose: single-cycle ALU ops (AND/OR/ADD/SUB/SLT/NOR/XOR) with overflow and illegal-op flags.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the enclosing FSM decides when the result is captured.
//
// Ports:
//   op        operation code
//   a, b      operands (A = rs, B = rt/immediate)
//   result    op result; shift codes pass B through (zero-amount shift result)
//   overflow  signed overflow, ADD/SUB only
//   illegal   op code outside the supported set
module alu_comb_core
  import mips_alu_pkg::*;
#(
  parameter int BITS_DATA = BITS_DATA_DEF,
  parameter int ALU_OP    = ALU_OP_W
) (
  input  logic [ALU_OP-1:0]    op,
  input  logic [BITS_DATA-1:0] a,
  input  logic [BITS_DATA-1:0] b,
  output logic [BITS_DATA-1:0] result,
  output logic                 overflow,
  output logic                 illegal
);

  localparam int MSB = BITS_DATA - 1;

  logic [BITS_DATA-1:0] sum;
  logic [BITS_DATA-1:0] diff;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic                 a_lt_b;

  assign sum  = a + b;
  assign diff = a - b;

  // ADD overflows when both operands share a sign that the sum lost.
  assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  // SUB overflows when operand signs differ and the difference lost A's sign.
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  assign a_lt_b = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result   = sum;
        overflow = add_ovf;
      end
      OP_SUB: begin
        result   = diff;
        overflow = sub_ovf;
      end
      OP_SLT: result = {{(BITS_DATA-1){1'b0}}, a_lt_b};
      OP_NOR: result = ~(a | b);
      OP_XOR: result = a ^ b;
      // A shift reaching this path has amount 0, so the answer is B itself.
      OP_SLL, OP_SRL, OP_SRA: result = b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Purpose: execute-stage ALU; logic/arith in one cycle, shifts iterate one bit per cycle.
// Latency: 1 cycle from accept to o_valid, 1+k cycles for a shift by k (k>0).
// Backpressure: o_ready low while shifting or holding a result; o_valid held until i_ready.
//
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_valid / o_ready         request handshake from operand selection
//   i_alu_op, i_shamt_sel     decoder op code and shift-amount source select
//   i_a, i_b, i_shamt         operands; B is the value shifted
//   o_valid / i_ready         result handshake toward EX/MEM
//   o_result, o_zero,
//   o_overflow, o_illegal     registered result and flags
module alu_iter_exec
  import mips_alu_pkg::*;
#(
  parameter int BITS_DATA  = BITS_DATA_DEF,
  parameter int ALU_OP     = ALU_OP_W,
  parameter int BITS_SHAMT = $clog2(BITS_DATA)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ALU_OP-1:0]     i_alu_op,
  input  logic                  i_shamt_sel,
  input  logic [BITS_DATA-1:0]  i_a,
  input  logic [BITS_DATA-1:0]  i_b,
  input  logic [BITS_SHAMT-1:0] i_shamt,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BITS_DATA-1:0]  o_result,
  output logic                  o_zero,
  output logic                  o_overflow,
  output logic                  o_illegal
);

  localparam int MSB = BITS_DATA - 1;

  alu_state_t            state;
  logic [BITS_SHAMT-1:0] cnt;
  logic [BITS_DATA-1:0]  work;
  logic                  shift_left;
  logic                  fill_bit;

  logic [BITS_SHAMT-1:0] amount;
  logic [BITS_DATA-1:0]  core_result;
  logic                  core_overflow;
  logic                  core_illegal;
  logic [BITS_DATA-1:0]  work_next;

  // Variable shifts take their amount from the low bits of rs.
  assign amount = i_shamt_sel ? i_shamt : i_a[BITS_SHAMT-1:0];

  // Ready is a pure state decode so upstream sees the stall immediately.
  assign o_ready = (state == ST_IDLE);

  alu_comb_core #(
    .BITS_DATA (BITS_DATA),
    .ALU_OP    (ALU_OP)
  ) u_core (
    .op       (i_alu_op),
    .a        (i_a),
    .b        (i_b),
    .result   (core_result),
    .overflow (core_overflow),
    .illegal  (core_illegal)
  );

  // One-bit step of the working register. fill_bit was latched at accept:
  // B's sign for SRA, 0 for SRL, so later input changes cannot leak in.
  assign work_next = shift_left ? {work[MSB-1:0], 1'b0}
                                : {fill_bit, work[MSB:1]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      work       <= '0;
      shift_left <= 1'b0;
      fill_bit   <= 1'b0;
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_zero     <= 1'b1;
      o_overflow <= 1'b0;
      o_illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            if (is_shift_op(i_alu_op) && (amount != '0)) begin
              state      <= ST_SHIFT;
              cnt        <= amount;
              work       <= i_b;
              shift_left <= (i_alu_op == OP_SLL);
              fill_bit   <= (i_alu_op == OP_SRA) ? i_b[MSB] : 1'b0;
            end else begin
              state      <= ST_DONE;
              o_valid    <= 1'b1;
              o_result   <= core_result;
              o_zero     <= (core_result == '0);
              o_overflow <= core_overflow;
              o_illegal  <= core_illegal;
            end
          end
        end

        ST_SHIFT: begin
          work <= work_next;
          cnt  <= cnt - BITS_SHAMT'(1);
          // The last step lands straight in the output registers.
          if (cnt == BITS_SHAMT'(1)) begin
            state      <= ST_DONE;
            o_valid    <= 1'b1;
            o_result   <= work_next;
            o_zero     <= (work_next == '0);
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
          end
        end

        ST_DONE: begin
          // Result and flags stay untouched until downstream takes them.
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
module tb_alu_iter_exec;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_alu_op;
  logic        i_shamt_sel;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [4:0]  i_shamt;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_zero;
  logic        o_overflow;
  logic        o_illegal;

  int errors = 0;
  int checks = 0;

  alu_iter_exec dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_alu_op    (i_alu_op),
    .i_shamt_sel (i_shamt_sel),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_shamt     (i_shamt),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_zero      (o_zero),
    .o_overflow  (o_overflow),
    .o_illegal   (o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
    int          lat;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: direct arithmetic from the op-code table, overflow judged by
  // whether the exact signed result fits in 32 bits.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic sel, input logic [4:0] sh);
    exp_t   e;
    int     k;
    longint sa, sb, s;
    longint smax;
    longint smin;
    smax = 2147483647;
    smin = -smax - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    k  = sel ? int'(sh) : int'(a[4:0]);
    e.res = 32'h0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin s = sa + sb; e.res = a + b; e.ovf = (s > smax) || (s < smin); end
      4'b0110: begin s = sa - sb; e.res = a - b; e.ovf = (s > smax) || (s < smin); end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
      4'b1101: e.res = a ^ b;
      4'b0011: begin e.res = b << k; e.lat = (k == 0) ? 1 : k + 1; end
      4'b0100: begin e.res = b >> k; e.lat = (k == 0) ? 1 : k + 1; end
      4'b0101: begin e.res = $signed(b) >>> k; e.lat = (k == 0) ? 1 : k + 1; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic scramble_inputs();
    i_alu_op    = 4'($urandom);
    i_shamt_sel = 1'($urandom);
    i_a         = $urandom;
    i_b         = $urandom;
    i_shamt     = 5'($urandom);
  endtask

  // Issue one op and check result, flags and latency. Starts and ends on a
  // negedge. When i_ready is high, also checks the return to idle.
  task automatic do_op(input string name, input vec_t v);
    int n;
    bit rdy_low;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      chk({name, " accept timeout"}, 32'(o_ready), 32'd1);
      return;
    end
    i_alu_op = v.op; i_a = v.a; i_b = v.b; i_shamt_sel = v.sel; i_shamt = v.sh;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    scramble_inputs();
    n = 0;
    rdy_low = 1'b1;
    while (n < 40) begin
      @(negedge i_clk);
      n++;
      if (o_valid) break;
      if (o_ready) rdy_low = 1'b0;
    end
    chk({name, " o_valid"},    32'(o_valid), 32'd1);
    chk({name, " latency"},    32'(n), 32'(v.lat));
    chk({name, " result"},     o_result, v.res);
    chk({name, " zero"},       32'(o_zero), 32'(v.res == 32'h0));
    chk({name, " overflow"},   32'(o_overflow), 32'(v.ovf));
    chk({name, " illegal"},    32'(o_illegal), 32'(v.ill));
    chk({name, " ready low"},  32'(rdy_low && !o_ready), 32'd1);
    if (i_ready) begin
      @(negedge i_clk);
      chk({name, " idle valid"}, 32'(o_valid), 32'd0);
      chk({name, " idle ready"}, 32'(o_ready), 32'd1);
    end
  endtask

  vec_t tbl[15];

  initial begin
    vec_t v;
    exp_t e;
    logic [3:0] ops[11];
    logic [31:0] held;
    bit stable;
    bit saw_valid;

    tbl[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd0,  32'h80000000, 1'b1, 1'b0, 1};
    tbl[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 1'b1, 5'd0,  32'h00000000, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'b0101, 32'h00000000, 32'hF0000000, 1'b1, 5'd4,  32'hFF000000, 1'b0, 1'b0, 5};
    tbl[3]  = '{4'b0011, 32'h00000023, 32'h00000001, 1'b0, 5'd0,  32'h00000008, 1'b0, 1'b0, 4};
    tbl[4]  = '{4'b0011, 32'h00000000, 32'hDEADBEEF, 1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1};
    tbl[5]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd0,  32'h00000001, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'b1010, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5'd3,  32'h00000000, 1'b0, 1'b1, 1};
    tbl[7]  = '{4'b0110, 32'h80000000, 32'h00000001, 1'b1, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 1};
    tbl[8]  = '{4'b0100, 32'h00000000, 32'h80000000, 1'b1, 5'd31, 32'h00000001, 1'b0, 1'b0, 32};
    tbl[9]  = '{4'b1100, 32'h00000000, 32'h00000000, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1};
    tbl[10] = '{4'b1101, 32'hA5A5A5A5, 32'hFFFF0000, 1'b1, 5'd0,  32'h5A5AA5A5, 1'b0, 1'b0, 1};
    tbl[11] = '{4'b0101, 32'h00000000, 32'h80000000, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
    tbl[12] = '{4'b0010, 32'h80000000, 32'h80000000, 1'b1, 5'd0,  32'h00000000, 1'b1, 1'b0, 1};
    tbl[13] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 1'b1, 5'd0,  32'h00000000, 1'b0, 1'b0, 1};
    tbl[14] = '{4'b0100, 32'h000000E4, 32'hF0F0F0F0, 1'b0, 5'd9,  32'h0F0F0F0F, 1'b0, 1'b0, 5};

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1111};

    i_reset_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    scramble_inputs();
    repeat (2) @(negedge i_clk);
    chk("reset ready",    32'(o_ready), 32'd1);
    chk("reset valid",    32'(o_valid), 32'd0);
    chk("reset result",   o_result, 32'h0);
    chk("reset zero",     32'(o_zero), 32'd1);
    chk("reset overflow", 32'(o_overflow), 32'd0);
    chk("reset illegal",  32'(o_illegal), 32'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 15; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      v.op  = (i % 7 == 6) ? 4'($urandom) : ops[$urandom_range(0, 10)];
      v.a   = $urandom;
      v.b   = $urandom;
      v.sel = 1'($urandom);
      v.sh  = 5'($urandom);
      if (i % 5 == 0) v.a = v.a | 32'h80000000;
      e = model(v.op, v.a, v.b, v.sel, v.sh);
      v.res = e.res; v.ovf = e.ovf; v.ill = e.ill; v.lat = e.lat;
      do_op($sformatf("rnd%0d op%h", i, v.op), v);
    end

    // Backpressure: result held 10 cycles while inputs and i_valid churn.
    i_ready = 1'b0;
    v = '{4'b1101, 32'h0000FFFF, 32'h00FF00FF, 1'b1, 5'd0, 32'h00FFFF00, 1'b0, 1'b0, 1};
    do_op("bp", v);
    held = o_result;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      i_valid = 1'($urandom);
      scramble_inputs();
      @(negedge i_clk);
      if (!o_valid || o_ready || o_result !== 32'h00FFFF00 || o_zero || o_overflow || o_illegal)
        stable = 1'b0;
    end
    chk("bp held stable", 32'(stable), 32'd1);
    chk("bp held value", held, 32'h00FFFF00);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp release valid", 32'(o_valid), 32'd0);
    chk("bp release ready", 32'(o_ready), 32'd1);

    // Reset during the third cycle of a 20-bit SRL abandons it.
    i_alu_op = 4'b0100; i_a = 32'h0; i_b = 32'hFFFFFFFF; i_shamt_sel = 1'b1; i_shamt = 5'd20;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("mid-shift ready low", 32'(o_ready), 32'd0);
    i_reset_n = 1'b0;
    #1;
    chk("rst ready",    32'(o_ready), 32'd1);
    chk("rst valid",    32'(o_valid), 32'd0);
    chk("rst result",   o_result, 32'h0);
    chk("rst zero",     32'(o_zero), 32'd1);
    chk("rst overflow", 32'(o_overflow), 32'd0);
    chk("rst illegal",  32'(o_illegal), 32'd0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge i_clk);
      if (o_valid) saw_valid = 1'b1;
    end
    chk("no result after reset", 32'(saw_valid), 32'd0);
    v = '{4'b0000, 32'h000000FF, 32'h0000000F, 1'b1, 5'd0, 32'h0000000F, 1'b0, 1'b0, 1};
    do_op("post-reset and", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
